fetch_queue: RTL and testbench

//   Fetch-side stage directly upstream of decode. Owns the fetch PC, drives the

---
 rtl/fetch_queue.sv | 140 ++++++++++++++
 tb/tb_fetch_queue.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue
//   Fetch stage in front of decode. Owns the fetch PC, drives the combinational
//   instruction memory address, stores each returned instruction together with
//   its PC in a DEPTH-entry FIFO and presents the FIFO head to decode over a
//   valid/ready handshake. A redirect flushes the FIFO and reloads the fetch PC.
//
// Parameters
//   DEPTH     queue entries, power of 2, >= 2
//   RESET_PC  fetch PC after reset, bits [1:0] zero
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   imem_addr_o    fetch address to imem (current fetch PC)
//   imem_instr_i   instruction at imem_addr_o, same cycle
//   redirect_i     flush queue, restart fetch at redirect_pc_i
//   redirect_pc_i  redirect target, bits [1:0] ignored
//   id_valid_o     head entry valid for decode
//   id_ready_i     decode accepts head this cycle
//   id_pc_o        PC of presented instruction (0 when invalid)
//   id_instr_o     presented instruction (0 when invalid)
//   count_o        occupied FIFO entries
//
// Configuration
//   FETCH_BYPASS_EN  when defined, an empty queue forwards imem straight to
//                    decode in the same cycle; an accepted bypass instruction
//                    never enters the FIFO.

module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [31:0]                  imem_addr_o,
  input  logic [31:0]                  imem_instr_i,
  input  logic                         redirect_i,
  input  logic [31:0]                  redirect_pc_i,
  output logic                         id_valid_o,
  input  logic                         id_ready_i,
  output logic [31:0]                  id_pc_o,
  output logic [31:0]                  id_instr_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic          fifo_empty;
  logic          bypass;
  logic          valid;
  logic          pop;
  logic          pop_fifo;
  logic          push_fifo;
  logic          advance;
  logic [31:0]   head_pc;
  logic [31:0]   head_instr;

  // Low target bits are discarded by definition.
  logic          unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  assign fifo_empty = (count_q == '0);

  always_comb begin
    bypass     = 1'b0;
    head_pc    = pc_mem_q[rd_ptr_q];
    head_instr = instr_mem_q[rd_ptr_q];
`ifdef FETCH_BYPASS_EN
    // rst gates the bypass so outputs read zero while reset is held.
    bypass = fifo_empty & ~redirect_i & rst;
    if (bypass) begin
      head_pc    = fetch_pc_q;
      head_instr = imem_instr_i;
    end
`endif
    valid = (~fifo_empty & ~redirect_i) | bypass;
    pop   = valid & id_ready_i & ~redirect_i;

    // A consumed bypass instruction advances fetch without touching the FIFO.
    pop_fifo  = pop & ~bypass;
    push_fifo = ~redirect_i & ((count_q < CW'(DEPTH)) | pop_fifo) & ~(bypass & pop);
    advance   = push_fifo | (bypass & pop);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (advance)   fetch_pc_d = fetch_pc_q + 32'd4;
      if (push_fifo) wr_ptr_d   = wr_ptr_q + PW'(1);
      if (pop_fifo)  rd_ptr_d   = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_fifo) - CW'(pop_fifo);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_fifo) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_instr_i;
    end
  end

  assign imem_addr_o = fetch_pc_q;
  assign id_valid_o  = valid;
  assign id_pc_o     = valid ? head_pc    : 32'd0;
  assign id_instr_o  = valid ? head_instr : 32'd0;
  assign count_o     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
  logic [2:0]  count_o;

  int n_cmp = 0;
  int n_err = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr_o   (imem_addr_o),
    .imem_instr_i  (imem_instr_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .id_pc_o       (id_pc_o),
    .id_instr_o    (id_instr_o),
    .count_o       (count_o)
  );

  // Combinational instruction memory.
  assign imem_instr_i = imem_addr_o ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {pc, instr} fetched but not yet delivered,
  // plus the model fetch PC. Updated once per cycle from the inputs that will
  // be sampled at the next rising edge.
  logic [63:0] sb[$];
  logic [31:0] model_pc;

  always @(negedge clk) begin
    logic        byp;
    logic        exp_valid;
    logic        pop;
    logic [63:0] head;
    if (!rst) begin
      chk("rst_valid", 32'(id_valid_o), 32'd0);
      chk("rst_count", 32'(count_o), 32'd0);
      chk("rst_pc", id_pc_o, 32'd0);
      chk("rst_instr", id_instr_o, 32'd0);
      sb.delete();
      model_pc = RESET_PC;
    end else begin
      chk("imem_addr", imem_addr_o, model_pc);
      chk("count", 32'(count_o), 32'(sb.size()));
      byp = 1'b0;
`ifdef FETCH_BYPASS_EN
      byp = (sb.size() == 0) && !redirect_i;
`endif
      exp_valid = ((sb.size() != 0) && !redirect_i) || byp;
      chk("id_valid", 32'(id_valid_o), 32'(exp_valid));
      if (exp_valid) begin
        head = byp ? {model_pc, model_pc ^ KEY} : sb[0];
        chk("id_pc", id_pc_o, head[63:32]);
        chk("id_instr", id_instr_o, head[31:0]);
      end else begin
        chk("idle_pc", id_pc_o, 32'd0);
        chk("idle_instr", id_instr_o, 32'd0);
      end
      if (redirect_i) begin
        sb.delete();
        model_pc = {redirect_pc_i[31:2], 2'b00};
      end else begin
        pop = exp_valid && id_ready_i;
        if (byp && pop) begin
          model_pc = model_pc + 32'd4;
        end else begin
          if (pop) void'(sb.pop_front());
          if (sb.size() < DEPTH) begin
            sb.push_back({model_pc, model_pc ^ KEY});
            model_pc = model_pc + 32'd4;
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycles(2);
    rst = 1'b1;
  endtask

  initial begin
    rst           = 1'b0;
    id_ready_i    = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    cycles(3);

    // Stream from reset with decode always ready.
    rst        = 1'b1;
    id_ready_i = 1'b1;
    cycles(8);

    // Backpressure fills the queue, fetch stalls at 0x10.
    do_reset();
    id_ready_i = 1'b0;
    cycles(10);
    chk("full_count", 32'(count_o), 32'd4);
    chk("full_addr", imem_addr_o, 32'h10);
    // Drain while refilling: full plus pop every cycle.
    id_ready_i = 1'b1;
    cycles(8);
    chk("steady_count", 32'(count_o), 32'd4);

    // Three queued entries, then redirect to an unaligned target.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0040;
    cycles(1);
    redirect_i = 1'b0;
    id_ready_i = 1'b0;
    cycles(3);
    chk("pre_redirect_count", 32'(count_o), 32'd3);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    id_ready_i    = 1'b1;
    cycles(1);
    chk("redirect_count", 32'(count_o), 32'd0);
    chk("redirect_addr", imem_addr_o, 32'h100);
    redirect_i = 1'b0;
    cycles(5);

    // Held redirect, then wrap of the fetch PC past 0xFFFF_FFFC.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFF8;
    cycles(3);
    redirect_i = 1'b0;
    cycles(6);

    // Reset mid-stream with two entries queued.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_2000;
    cycles(1);
    redirect_i = 1'b0;
    id_ready_i = 1'b0;
    cycles(2);
    rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(count_o), 32'd0);
    chk("async_rst_valid", 32'(id_valid_o), 32'd0);
    cycles(2);
    rst        = 1'b1;
    id_ready_i = 1'b1;
    cycles(1);
    chk("restart_addr", imem_addr_o, RESET_PC + 32'd4);
    cycles(4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      id_ready_i    = ($urandom_range(99) < 65);
      redirect_i    = ($urandom_range(99) < 5);
      redirect_pc_i = $urandom();
      rst           = ($urandom_range(199) != 0);
      cycles(1);
    end
    rst        = 1'b1;
    redirect_i = 1'b0;
    cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
